// File: rtl/bias_add_array.sv
// ---------------------------------------------------------------------------
// bias_add_array
//
// Two-stage, multi-lane bias adder for the convolution output path. Each of
// the CHAN_NB signed lanes gets a per-kernel, per-lane bias added. The sum
// saturates to NUM_WIDTH bits and can optionally be rectified (ReLU). Biases
// come from an internal table of BIAS_DEPTH kernel entries. The table is
// addressed by a kernel pointer that advances on every accepted up_last beat.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_relu               1 = clamp negative results to zero (used in stage 2)
//   cfg_kernels            kernels per pass (0 treated as 1, clamped to depth)
//   ptr_clr                synchronous kernel-pointer clear
//   bias_wr/addr/data      bias table write port (read-first w.r.t. stage 1)
//   up_data/valid/last     upstream beat, up_ready = accept
//   dn_data/valid/last     downstream beat, dn_ready = accept
//   Lane i of any data bus sits at [i*NUM_WIDTH +: NUM_WIDTH].
// ---------------------------------------------------------------------------
module bias_add_array #(
    parameter int NUM_WIDTH   = 16,
    parameter int CHAN_NB     = 4,
    parameter int BIAS_DEPTH  = 64,
    parameter int BIAS_AWIDTH = $clog2(BIAS_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_relu,
    input  logic [BIAS_AWIDTH:0]           cfg_kernels,
    input  logic                           ptr_clr,
    input  logic                           bias_wr,
    input  logic [BIAS_AWIDTH-1:0]         bias_addr,
    input  logic [CHAN_NB*NUM_WIDTH-1:0]   bias_data,
    input  logic [CHAN_NB*NUM_WIDTH-1:0]   up_data,
    input  logic                           up_valid,
    input  logic                           up_last,
    output logic                           up_ready,
    output logic [CHAN_NB*NUM_WIDTH-1:0]   dn_data,
    output logic                           dn_valid,
    output logic                           dn_last,
    input  logic                           dn_ready
);

    localparam int DW = CHAN_NB * NUM_WIDTH;
    localparam logic [BIAS_AWIDTH:0] DEPTH_W = (BIAS_AWIDTH+1)'(BIAS_DEPTH);
    localparam logic [NUM_WIDTH-1:0] SAT_MAX = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic [NUM_WIDTH-1:0] SAT_MIN = {1'b1, {(NUM_WIDTH-1){1'b0}}};

    // Both stages share one enable: the whole pipe moves or freezes together.
    logic en;
    logic accept;
    assign en       = !dn_valid || dn_ready;
    assign up_ready = en;
    assign accept   = up_valid && en;

    // ------------------------------------------------------------------
    // Kernel pointer
    // ------------------------------------------------------------------
    logic [BIAS_AWIDTH-1:0] k_ptr_reg, k_ptr_next;
    logic [BIAS_AWIDTH:0]   eff_kernels;
    logic [BIAS_AWIDTH:0]   last_idx;

    always_comb begin
        eff_kernels = cfg_kernels;
        if (cfg_kernels == '0) begin
            eff_kernels = (BIAS_AWIDTH+1)'(1);
        end else if (cfg_kernels > DEPTH_W) begin
            eff_kernels = DEPTH_W;
        end
    end

    assign last_idx = eff_kernels - (BIAS_AWIDTH+1)'(1);

    always_comb begin
        k_ptr_next = k_ptr_reg;
        if (ptr_clr) begin
            // Clear wins over a same-cycle advance; that beat already read old k_ptr.
            k_ptr_next = '0;
        end else if (accept && up_last) begin
            // >= rather than == so a pointer left beyond a shrunk pass still wraps.
            if ({1'b0, k_ptr_reg} >= last_idx) begin
                k_ptr_next = '0;
            end else begin
                k_ptr_next = k_ptr_reg + BIAS_AWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_ptr_reg <= '0;
        end else begin
            k_ptr_reg <= k_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Bias table: not reset, read-first, read enabled with the pipe so the
    // stage-1 bias stays paired with its stalled data.
    // ------------------------------------------------------------------
    logic [DW-1:0] bias_mem [BIAS_DEPTH];
    logic [DW-1:0] s1_bias_reg;

    always_ff @(posedge clk) begin
        if (bias_wr) begin
            bias_mem[bias_addr] <= bias_data;
        end
        if (en) begin
            s1_bias_reg <= bias_mem[k_ptr_reg];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: data / last / valid
    // ------------------------------------------------------------------
    logic          s1_valid_reg;
    logic          s1_last_reg;
    logic [DW-1:0] s1_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_data_reg  <= '0;
        end else if (en) begin
            s1_valid_reg <= up_valid;
            s1_last_reg  <= up_last;
            s1_data_reg  <= up_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: per-lane add, saturate, optional ReLU
    // ------------------------------------------------------------------
    logic [DW-1:0] lane_result;

    for (genvar gi = 0; gi < CHAN_NB; gi++) begin : g_lane
        logic [NUM_WIDTH-1:0] a;
        logic [NUM_WIDTH-1:0] b;
        logic [NUM_WIDTH:0]   sum;
        logic [NUM_WIDTH-1:0] sat;
        logic [NUM_WIDTH-1:0] res;

        assign a   = s1_data_reg[gi*NUM_WIDTH +: NUM_WIDTH];
        assign b   = s1_bias_reg[gi*NUM_WIDTH +: NUM_WIDTH];
        assign sum = {a[NUM_WIDTH-1], a} + {b[NUM_WIDTH-1], b};

        always_comb begin
            // Top two bits disagree only when the W+1-bit sum left the W-bit range.
            sat = sum[NUM_WIDTH-1:0];
            if (sum[NUM_WIDTH] != sum[NUM_WIDTH-1]) begin
                sat = sum[NUM_WIDTH] ? SAT_MIN : SAT_MAX;
            end
            res = sat;
            if (cfg_relu && sat[NUM_WIDTH-1]) begin
                res = '0;
            end
        end

        assign lane_result[gi*NUM_WIDTH +: NUM_WIDTH] = res;
    end

    logic          dn_valid_reg;
    logic          dn_last_reg;
    logic [DW-1:0] dn_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid_reg <= 1'b0;
            dn_last_reg  <= 1'b0;
            dn_data_reg  <= '0;
        end else if (en) begin
            dn_valid_reg <= s1_valid_reg;
            // Bubbles leave the data register alone so it never sees unwritten bias.
            if (s1_valid_reg) begin
                dn_last_reg <= s1_last_reg;
                dn_data_reg <= lane_result;
            end
        end
    end

    assign dn_valid = dn_valid_reg;
    assign dn_last  = dn_last_reg;
    assign dn_data  = dn_data_reg;

endmodule
